// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory, little-endian, one byte per clock.
// Latency: a handshake at edge n writes bytes in the four cycles after it; done or next in_ready follows.
// Backpressure: in_ready is high only in ACCEPT; words wait upstream while bytes are being written.
module imem_loader #(
  parameter int ADDR_W    = 5,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] word_count
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0]   BASE      = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W+1:0] MEM_BYTES = (ADDR_W+2)'(1) << ADDR_W;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   ptr;
  logic [1:0]        byte_idx;
  logic [1:0]        idx_nxt;
  logic [23:0]       word_sr;
  logic              last_q;
  logic              hs;
  logic              fits;

  assign hs      = in_valid && in_ready;
  // One extra bit beyond ptr so ptr+4 at the top of memory compares exactly.
  assign fits    = ({1'b0, ptr} + (ADDR_W+2)'(4)) <= MEM_BYTES;
  assign idx_nxt = byte_idx + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ACCEPT;
      end
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = fits ? WRITE : DONE;
      end
      WRITE: begin
        if (byte_idx == 2'd3) state_nxt = last_q ? DONE : ACCEPT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= BASE;
      byte_idx   <= 2'd0;
      word_sr    <= 24'h0;
      last_q     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr        <= BASE;
            word_count <= '0;
            error      <= 1'b0;
          end
        end
        ACCEPT: begin
          if (hs) begin
            last_q <= in_last;
            if (fits) begin
              // Byte 0 goes out straight from the input; the upper three are shifted out later.
              word_sr   <= in_data[31:8];
              byte_idx  <= 2'd0;
              mem_we    <= 1'b1;
              mem_addr  <= ptr[ADDR_W-1:0];
              mem_wdata <= in_data[7:0];
            end else begin
              error <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (byte_idx == 2'd3) begin
            mem_we     <= 1'b0;
            ptr        <= ptr + (ADDR_W+1)'(4);
            word_count <= word_count + (ADDR_W-1)'(1);
          end else begin
            byte_idx  <= idx_nxt;
            mem_addr  <= ptr[ADDR_W-1:0] + ADDR_W'(idx_nxt);
            mem_wdata <= word_sr[7:0];
            word_sr   <= {8'h00, word_sr[23:8]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed-sequence bench with randomized words and gaps; two loaders (base 0 and base 8) share the stimulus.
module tb_imem_loader;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [31:0] in_data = 32'h0;

  logic rdy0, we0, busy0, done0, err0;
  logic [AW-1:0] addr0;
  logic [7:0] wd0;
  logic [AW-2:0] wc0;
  logic rdy1, we1, busy1, done1, err1;
  logic [AW-1:0] addr1;
  logic [7:0] wd1;
  logic [AW-2:0] wc1;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_last(in_last), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
    .busy(busy0), .done(done0), .error(err0), .word_count(wc0));

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_last(in_last), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .busy(busy1), .done(done1), .error(err1), .word_count(wc1));

  // Behavioural memories and write monitors. Period label = number of rising edges seen so far;
  // the period right after handshake edge n carries label n (the specification's cycle n+1).
  logic [7:0] mem0 [32];
  logic [7:0] mem1 [32];
  int wcnt0 [32];
  int cyc = 0, nwr0 = 0, ndone0 = 0, done_cyc1 = -1;
  int wlog_a[$], wlog_d[$], wlog_c[$];

  always @(posedge clk) begin
    if (we0) begin mem0[addr0] = wd0; wcnt0[addr0]++; nwr0++; end
    if (done0) ndone0++;
    if (we1) begin
      mem1[addr1] = wd1;
      wlog_a.push_back(int'(addr1));
      wlog_d.push_back(int'(wd1));
      wlog_c.push_back(cyc);
    end
    if (done1) done_cyc1 = cyc;
    cyc++;
  end

  int checks = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon(input logic [7:0] fill);
    for (int a = 0; a < 32; a++) begin mem0[a] = fill; mem1[a] = fill; wcnt0[a] = 0; end
    nwr0 = 0; ndone0 = 0; done_cyc1 = -1;
    wlog_a.delete(); wlog_d.delete(); wlog_c.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_in_ready"}, 32'(rdy0), 0);
    check({tag, "_mem_we"}, 32'(we0), 0);
    check({tag, "_busy"}, 32'(busy0), 0);
    check({tag, "_done"}, 32'(done0), 0);
    check({tag, "_error"}, 32'(err0), 0);
    check({tag, "_mem_addr"}, 32'(addr0), 0);
    check({tag, "_mem_wdata"}, 32'(wd0), 0);
    check({tag, "_word_count"}, 32'(wc0), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_in_ready", 32'(rdy0), 1);
    check("start_busy", 32'(busy0), 1);
  endtask

  task automatic send_word(input logic [31:0] w, input logic l, output int hs);
    int n = 0;
    in_valid = 1'b1; in_data = w; in_last = l;
    while (!rdy0 && n < 50) begin @(posedge clk); #1; n++; end
    check("handshake_timeout", 32'(n < 50), 1);
    @(posedge clk); #1;
    hs = cyc;
    in_valid = 1'b0; in_data = $urandom; in_last = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done0 && n < budget) begin @(posedge clk); #1; n++; end
    check("done_timeout", 32'(done0), 1);
  endtask

  // Reference image: word i lands little-endian at 4*i while it fits below 32 bytes.
  task automatic check_image0(input string tag, input logic [31:0] ws[$]);
    logic [7:0] exp_b [32];
    int exp_n [32];
    for (int a = 0; a < 32; a++) begin exp_b[a] = 8'h00; exp_n[a] = 0; end
    for (int i = 0; i < ws.size(); i++)
      if (4 * (i + 1) <= 32)
        for (int k = 0; k < 4; k++) begin
          exp_b[4*i+k] = 8'((ws[i] >> (8 * k)) & 32'hff);
          exp_n[4*i+k] = exp_n[4*i+k] + 1;
        end
    for (int a = 0; a < 32; a++) begin
      check($sformatf("%s_byte[%0d]", tag, a), 32'(mem0[a]), 32'(exp_b[a]));
      check($sformatf("%s_wrcnt[%0d]", tag, a), 32'(wcnt0[a]), 32'(exp_n[a]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prog[$];
    logic [31:0] ws[$];
    logic [31:0] a, b, w;
    int hs, n0, n;

    prog = '{32'h00900493, 32'h00500293, 32'hfe54ae23, 32'hffc4a303,
             32'h0064a423, 32'h0062e233, 32'hfe420ae3};

    // Reset state
    #1;
    check_reset0("reset");
    idle(1);
    rst_n = 1'b1;
    idle(1);
    check_reset0("post_reset_idle");

    // 7-word program load with random gaps
    clear_mon(8'h00);
    do_start();
    for (int i = 0; i < 7; i++) begin
      send_word(prog[i], i == 6, hs);
      if (i != 6) idle($urandom_range(0, 3));
    end
    wait_done(10);
    idle(1);
    check("prog_writes", 32'(nwr0), 28);
    check("prog_byte0", 32'(mem0[0]), 32'h93);
    check("prog_byte3", 32'(mem0[3]), 32'h00);
    check("prog_byte24", 32'(mem0[24]), 32'hE3);
    check("prog_byte27", 32'(mem0[27]), 32'hFE);
    check("prog_word_count", 32'(wc0), 7);
    check("prog_done_pulses", 32'(ndone0), 1);
    check("prog_error", 32'(err0), 0);
    check("prog_busy_after", 32'(busy0), 0);
    check_image0("prog", prog);

    // Backpressure: in_valid low for 3 cycles between words 2 and 3
    do_reset();
    clear_mon(8'h00);
    do_start();
    send_word(prog[0], 1'b0, hs);
    send_word(prog[1], 1'b0, hs);
    n = 0;
    while (!rdy0 && n < 20) begin idle(1); n++; end
    check("bp_ready_timeout", 32'(rdy0), 1);
    n0 = nwr0;
    for (int i = 0; i < 3; i++) begin
      check("bp_wait_in_ready", 32'(rdy0), 1);
      check("bp_wait_mem_we", 32'(we0), 0);
      idle(1);
    end
    check("bp_wait_no_writes", 32'(nwr0), 32'(n0));
    for (int i = 2; i < 7; i++) send_word(prog[i], i == 6, hs);
    wait_done(10);
    idle(1);
    check("bp_word_count", 32'(wc0), 7);
    check_image0("bp", prog);

    // Single word on the base-8 loader: exact byte/cycle placement
    do_reset();
    clear_mon(8'h00);
    do_start();
    send_word(32'hDEADBEEF, 1'b1, hs);
    wait_done(10);
    idle(1);
    check("single_nwrites", 32'(wlog_a.size()), 4);
    for (int i = 0; i < 4 && i < wlog_a.size(); i++) begin
      check($sformatf("single_addr%0d", i), 32'(wlog_a[i]), 32'(8 + i));
      check($sformatf("single_data%0d", i), 32'(wlog_d[i]), (32'hDEADBEEF >> (8 * i)) & 32'hff);
      check($sformatf("single_cycle%0d", i), 32'(wlog_c[i]), 32'(hs + i));
    end
    check("single_done_cycle", 32'(done_cyc1), 32'(hs + 4));
    check("single_word_count", 32'(wc1), 1);
    check("single_error", 32'(err1), 0);

    // Overflow: 9 random words, no last
    do_reset();
    clear_mon(8'h00);
    ws.delete();
    do_start();
    for (int i = 0; i < 9; i++) begin
      w = $urandom;
      ws.push_back(w);
      send_word(w, 1'b0, hs);
      if (i != 8) idle($urandom_range(0, 2));
    end
    check("ovf_done", 32'(done0), 1);
    check("ovf_error", 32'(err0), 1);
    check("ovf_no_we", 32'(we0), 0);
    // start during DONE must be ignored
    start = 1'b1;
    idle(1);
    start = 1'b0;
    check("ovf_start_in_done_busy", 32'(busy0), 0);
    check("ovf_error_held", 32'(err0), 1);
    check("ovf_word_count", 32'(wc0), 8);
    check("ovf_writes", 32'(nwr0), 32);
    check("ovf_done_pulses", 32'(ndone0), 1);
    check_image0("ovf", ws);
    // honoured start clears error and word_count
    do_start();
    check("restart_error_clear", 32'(err0), 0);
    check("restart_wc_clear", 32'(wc0), 0);
    a = $urandom; b = $urandom;
    n0 = nwr0;
    send_word(a, 1'b0, hs);
    start = 1'b1;          // start during WRITE must be ignored
    idle(1);
    start = 1'b0;
    send_word(b, 1'b1, hs);
    wait_done(10);
    idle(1);
    check("restart_writes", 32'(nwr0 - n0), 8);
    check("restart_word_count", 32'(wc0), 2);
    check("restart_error", 32'(err0), 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("restart_a_byte%0d", k), 32'(mem0[k]), (a >> (8 * k)) & 32'hff);
      check($sformatf("restart_b_byte%0d", k), 32'(mem0[4+k]), (b >> (8 * k)) & 32'hff);
    end

    // Reset asserted while byte 2 is on the write port
    do_reset();
    clear_mon(8'h55);
    do_start();
    send_word(32'hA1B2C3D4, 1'b0, hs);
    idle(2);
    check("mid_we_byte2", 32'(we0), 1);
    check("mid_addr_byte2", 32'(addr0), 2);
    rst_n = 1'b0;
    #1;
    check_reset0("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = nwr0;
    in_valid = 1'b1; in_data = $urandom;
    for (int i = 0; i < 4; i++) begin
      check("post_reset_in_ready", 32'(rdy0), 0);
      idle(1);
    end
    in_valid = 1'b0;
    check("post_reset_no_writes", 32'(nwr0), 32'(n0));
    check("mid_byte0_kept", 32'(mem0[0]), 32'hD4);
    check("mid_byte1_kept", 32'(mem0[1]), 32'hC3);
    check("mid_byte2_unwritten", 32'(mem0[2]), 32'h55);
    check("mid_byte3_unwritten", 32'(mem0[3]), 32'h55);
    do_start();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writer side of the instruction memory: accepts 32-bit instruction words over a valid/ready stream and writes them little-endian, one byte per clock, into the instruction memory's byte-wide write port. A load session starts at a word-aligned base address. The fetch path keeps reading the same byte array through its combinational read port. Typical uses are boot-time program loading and in-bench program injection.

## Interface
- ADDR_W, 5: byte-address width of the instruction memory. Memory size is 2^ADDR_W bytes, a multiple of 4.
- BASE_ADDR, 0: first byte address of every session. Must be word aligned (BASE_ADDR[1:0]=0).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  begins a session. Honoured only in IDLE.
- in_valid  in  1  in_data/in_last are valid.
- in_ready  out  1  loader can accept a word this cycle.
- in_data  in  32  instruction word; bits [7:0] go to the lowest address.
- in_last  in  1  qualifies in_data as the final word of the session.
- mem_we  out  1  byte write strobe.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  byte to write.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at session end.
- error  out  1  sticky overflow flag; cleared by an honoured start.
- word_count  out  ADDR_W-1  words fully written in the current session.

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- Reset values: state IDLE; in_ready, mem_we, busy, done and error all 0; mem_addr, mem_wdata and word_count 0; ptr = BASE_ADDR.
- IDLE, start=1: ptr <= BASE_ADDR, word_count <= 0, error <= 0, next state ACCEPT. start is ignored in every other state.
- ACCEPT: in_ready=1. A handshake is in_valid && in_ready at the edge. On handshake, latch in_data and in_last.
  - If ptr+4 <= 2^ADDR_W: set byte_idx=0 and go to WRITE.
  - Otherwise (overflow): the word is consumed but not written, error <= 1, next state DONE.
- WRITE: one byte per cycle for byte_idx = 0..3.
  - mem_we=1, mem_addr=ptr+byte_idx, mem_wdata=word[8*byte_idx +: 8].
  - After byte_idx=3: ptr <= ptr+4 and word_count <= word_count+1.
  - Then go to DONE if the latched last=1, otherwise to ACCEPT.
- DONE: done=1 for exactly one cycle, then IDLE. ptr and word_count hold their values until the next honoured start.
- Arithmetic: ptr is ADDR_W+1 bits wide so the overflow compare is exact. mem_addr never wraps.
- in_ready is 0 in IDLE, WRITE and DONE. in_data is don't-care when in_valid=0.
- Reset mid-session: returns to IDLE immediately. The partial word is lost; bytes already written stay in memory.

## Timing
- start sampled at edge k → ACCEPT during cycle k+1 → in_ready=1 during cycle k+1.
- Handshake at edge n → bytes 0..3 written in cycles n+1..n+4 → in_ready=1 again in cycle n+5 (not last) → done=1 in cycle n+5 (last).
- Throughput is one word per 5 cycles when in_valid is held high.
- mem_* are registered outputs; the memory captures a byte on the edge ending a mem_we=1 cycle.
- Overflow handshake at edge n → done=1 and error=1 in cycle n+1, with no mem_we.
- in_valid may rise or fall at any time; only a sampled handshake counts.

## Test plan
- Load 7 words (0x00900493, 0x00500293, 0xfe54ae23, 0xffc4a303, 0x0064a423, 0x0062e233, 0xfe420ae3; last on word 7).
  - Required: 28 byte writes, addresses 0..27.
  - Required: byte[0]=0x93, byte[3]=0x00, byte[24]=0xE3, byte[27]=0xFE.
  - Required: word_count=7, a single done pulse, error=0.
- Backpressure: drop in_valid for 3 cycles between words 2 and 3. Required: no writes while waiting, the same final memory image as the 7-word load, and in_ready held high while waiting.
- Single word 0xDEADBEEF with last=1, BASE_ADDR=8. Required: bytes EF, BE, AD, DE at addresses 8..11 in cycles n+1..n+4, then done in cycle n+5.
- Overflow: send 9 words without last (ADDR_W=5). Required: 8 words written, 9th word consumed with no write, error=1, done pulse, word_count=8.
- Assert rst_n=0 during byte_idx=2 of a word. Required: all outputs return to reset values asynchronously, bytes 0..1 remain in memory, and in_ready stays 0 until the next start.
- Pulse start during WRITE and during DONE. Required: ignored, with no ptr or error change; a subsequent start in IDLE clears error and word_count.
